// File: rtl/aer_sample_sequencer.sv
// AER input sequencer: streams one sample's spike bitmaps from spike memory
// to the core as pixel/tick events over a 4-phase REQ/ACK handshake.
module aer_sample_sequencer #(
    parameter int N_PIX   = 784,
    parameter int T_STEPS = 8,
    parameter int WORD_W  = 32,
    parameter int MEM_AW  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [15:0]       SAMPLE_IDX,
    input  logic              LABEL_POS,
    input  logic              TRAIN_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [31:0]       GOODNESS_OUT,
    output logic [15:0]       SPIKE_CNT,
    output logic              ERR,
    output logic              MEM_REN,
    output logic [MEM_AW-1:0] MEM_RADDR,
    input  logic [WORD_W-1:0] MEM_RDATA,
    output logic [11:0]       AERIN_ADDR,
    output logic              AERIN_REQ,
    input  logic              AERIN_ACK,
    output logic              IS_POS,
    output logic              IS_TRAIN,
    input  logic              PROCESS_DONE,
    input  logic [31:0]       GOODNESS
);

    localparam int WPT = (N_PIX + WORD_W - 1) / WORD_W;
    localparam int BW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WW  = (WPT > 1) ? $clog2(WPT) : 1;
    localparam int TW  = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

    localparam logic [BW-1:0] B_LAST    = BW'(WORD_W - 1);
    localparam logic [WW-1:0] W_LAST    = WW'(WPT - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(T_STEPS - 1);
    localparam logic [11:0]   TICK_ADDR = 12'h4FF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_SCAN,
        S_SETUP,
        S_TICK_SETUP,
        S_REQ,
        S_REL,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [TW-1:0]     t_q, t_d;
    logic [WW-1:0]     word_q, word_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [11:0]       addr_q, addr_d;
    logic              tick_q, tick_d;
    logic              req_q, req_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       good_q, good_d;
    logic              err_q, err_d;
    logic              pos_q, pos_d;
    logic              train_q, train_d;

    logic [31:0]       pix;
    logic              pix_bit;
    logic              pix_pad;
    logic              adv;
    logic [MEM_AW-1:0] raddr;

    // State and datapath registers; reset aborts any sample in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            t_q     <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            tick_q  <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            good_q  <= '0;
            err_q   <= 1'b0;
            pos_q   <= 1'b0;
            train_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            train_q <= train_d;
        end
    end

    // Current bit under scan (MSB first), its pixel number and word address.
    always_comb begin
        pix     = 32'(word_q) * 32'(WORD_W) + 32'(bit_q);
        pix_bit = data_q[B_LAST - bit_q];
        pix_pad = (pix >= 32'(N_PIX));
        raddr   = (MEM_AW'(idx_q) * MEM_AW'(T_STEPS) + MEM_AW'(t_q))
                  * MEM_AW'(WPT) + MEM_AW'(word_q);
    end

    // Next-state logic: fetch, scan, handshake each event, then wait for core.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        word_d  = word_q;
        bit_d   = bit_q;
        data_d  = data_q;
        addr_d  = addr_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        err_d   = err_q;
        pos_d   = pos_q;
        train_d = train_q;
        adv     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    idx_d   = SAMPLE_IDX;
                    pos_d   = LABEL_POS;
                    train_d = TRAIN_EN;
                    cnt_d   = '0;
                    t_d     = '0;
                    word_d  = '0;
                    bit_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                data_d  = MEM_RDATA;
                bit_d   = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (pix_bit && !pix_pad) begin
                    addr_d  = {2'b00, pix[9:0]};
                    tick_d  = 1'b0;
                    state_d = S_SETUP;
                end else begin
                    adv = 1'b1;
                end
            end
            S_SETUP, S_TICK_SETUP: begin
                if (!AERIN_ACK) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (AERIN_ACK) begin
                    state_d = S_REL;
                    if (!tick_q && cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_REL: begin
                if (!AERIN_ACK) begin
                    if (!tick_q) begin
                        adv = 1'b1;
                    end else if (t_q == T_LAST) begin
                        state_d = S_WAIT_DONE;
                    end else begin
                        t_d     = t_q + 1'b1;
                        word_d  = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (PROCESS_DONE) begin
                    good_d  = GOODNESS;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (bit_q != B_LAST) begin
                bit_d   = bit_q + 1'b1;
                state_d = S_SCAN;
            end else if (word_q != W_LAST) begin
                word_d  = word_q + 1'b1;
                state_d = S_FETCH;
            end else begin
                addr_d  = TICK_ADDR;
                tick_d  = 1'b1;
                state_d = S_TICK_SETUP;
            end
        end

        if (PROCESS_DONE && state_q != S_WAIT_DONE) begin
            err_d = 1'b1;
        end

        req_d = (state_d == S_REQ);
    end

    // Output decode.
    always_comb begin
        BUSY         = (state_q != S_IDLE) && (state_q != S_FINISH);
        DONE         = (state_q == S_FINISH);
        MEM_REN      = (state_q == S_FETCH);
        MEM_RADDR    = (state_q == S_FETCH) ? raddr : '0;
        AERIN_ADDR   = addr_q;
        AERIN_REQ    = req_q;
        GOODNESS_OUT = good_q;
        SPIKE_CNT    = cnt_q;
        ERR          = err_q;
        IS_POS       = pos_q;
        IS_TRAIN     = train_q;
    end

endmodule

// File: tb/tb_aer_sample_sequencer.sv
// Bench for aer_sample_sequencer: spike memory model, randomized ACK
// responder and a bitmap-level event reference model.
module tb_aer_sample_sequencer;

    localparam int N_PIX   = 784;
    localparam int T_STEPS = 8;
    localparam int WORD_W  = 32;
    localparam int MEM_AW  = 16;
    localparam int WPT     = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] sample_idx = '0;
    logic        label_pos = 1'b0;
    logic        train_en = 1'b0;
    logic        ack = 1'b0;
    logic        pd = 1'b0;
    logic [31:0] goodness = '0;
    logic [31:0] rdata = '0;

    logic              busy, done, err, mem_ren, req, is_pos, is_train;
    logic [31:0]       goodness_out;
    logic [15:0]       spike_cnt;
    logic [MEM_AW-1:0] mem_raddr;
    logic [11:0]       aerin_addr;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [int];
    logic [11:0] events [$];
    logic [11:0] exp_ev [$];

    int   rd480 = 0;
    int   viol = 0;
    int   attr_viol = 0;
    int   ticks = 0;
    int   done_cnt = 0;
    int   rph = 0;
    int   dcnt = 0;
    int   dmin = 0;
    int   dmax = 3;
    bit   hold_ack = 1'b0;
    bit   exp_pos = 1'b0;
    bit   exp_train = 1'b0;
    logic req_prev = 1'b0;
    logic [11:0] addr_prev = '0;
    logic [11:0] cur = '0;

    always #5 clk = ~clk;

    aer_sample_sequencer dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .START        (start),
        .SAMPLE_IDX   (sample_idx),
        .LABEL_POS    (label_pos),
        .TRAIN_EN     (train_en),
        .BUSY         (busy),
        .DONE         (done),
        .GOODNESS_OUT (goodness_out),
        .SPIKE_CNT    (spike_cnt),
        .ERR          (err),
        .MEM_REN      (mem_ren),
        .MEM_RADDR    (mem_raddr),
        .MEM_RDATA    (rdata),
        .AERIN_ADDR   (aerin_addr),
        .AERIN_REQ    (req),
        .AERIN_ACK    (ack),
        .IS_POS       (is_pos),
        .IS_TRAIN     (is_train),
        .PROCESS_DONE (pd),
        .GOODNESS     (goodness)
    );

    // Spike memory: data returned the cycle after a read enable.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_ren) begin
                rdata <= mem.exists(int'(mem_raddr)) ? mem[int'(mem_raddr)] : 32'h0;
                if (mem_raddr == 16'd480) rd480 <= rd480 + 1;
            end
        end
    end

    // Core side of the 4-phase handshake plus protocol monitors.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0;
                rph = 0;
            end else begin
                if (req && !req_prev && ack) viol++;
                if (req && !req_prev && aerin_addr !== addr_prev) viol++;
                if (busy && (is_pos !== exp_pos || is_train !== exp_train))
                    attr_viol++;
                if (done) done_cnt++;
                if (hold_ack) begin
                    ack = 1'b1;
                end else begin
                    case (rph)
                        0: if (req) begin
                            cur  = aerin_addr;
                            dcnt = int'($urandom_range(dmax, dmin));
                            rph  = 1;
                        end
                        1: begin
                            if (!req || aerin_addr !== cur) viol++;
                            if (dcnt == 0) begin
                                ack = 1'b1;
                                events.push_back(cur);
                                if (cur == 12'h4FF) ticks++;
                                rph = 2;
                            end else begin
                                dcnt--;
                            end
                        end
                        2: begin
                            if (aerin_addr !== cur) viol++;
                            if (!req) begin
                                dcnt = int'($urandom_range(dmax, dmin));
                                rph  = 3;
                            end
                        end
                        default: begin
                            if (aerin_addr !== cur || req) viol++;
                            if (dcnt == 0) begin
                                ack = 1'b0;
                                rph = 0;
                            end else begin
                                dcnt--;
                            end
                        end
                    endcase
                end
            end
            req_prev  = req;
            addr_prev = aerin_addr;
        end
    end

    initial begin
        #950us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int word_addr(input int idx, input int t, input int p);
        return (idx * T_STEPS + t) * WPT + p / WORD_W;
    endfunction

    task automatic set_pixel(input int idx, input int t, input int p);
        int a;
        logic [31:0] w;
        a = word_addr(idx, t, p);
        w = mem.exists(a) ? mem[a] : 32'h0;
        w[WORD_W - 1 - (p % WORD_W)] = 1'b1;
        mem[a] = w;
    endtask

    // Reference: walk every step and pixel of the bitmap, one event per set
    // pixel in ascending order, then a tick per step.
    task automatic build_expected(input int idx);
        int a;
        logic [31:0] w;
        exp_ev.delete();
        for (int t = 0; t < T_STEPS; t++) begin
            for (int p = 0; p < N_PIX; p++) begin
                a = word_addr(idx, t, p);
                w = mem.exists(a) ? mem[a] : 32'h0;
                if (w[WORD_W - 1 - (p % WORD_W)]) exp_ev.push_back(12'(p));
            end
            exp_ev.push_back(12'h4FF);
        end
    endtask

    function automatic int ev_diffs();
        int d = 0;
        if (events.size() != exp_ev.size()) d++;
        foreach (exp_ev[i])
            if (i < events.size() && events[i] !== exp_ev[i]) d++;
        return d;
    endfunction

    function automatic int exp_pixels();
        int n = 0;
        foreach (exp_ev[i]) if (exp_ev[i] != 12'h4FF) n++;
        return n;
    endfunction

    task automatic run_sample(input int idx, input bit pos, input bit trn,
                              input logic [31:0] good, input int restart_at,
                              input int pd_at, input int hold_n,
                              output bit tmo, output bit early, output bit got);
        int n;
        int dc0;
        bit rs_done;
        bit pd_done;
        events.delete();
        ticks   = 0;
        tmo     = 1'b0;
        got     = 1'b0;
        rs_done = 1'b0;
        pd_done = 1'b0;
        @(negedge clk);
        exp_pos    = pos;
        exp_train  = trn;
        dc0        = done_cnt;
        sample_idx = 16'(idx);
        label_pos  = pos;
        train_en   = trn;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(ticks == T_STEPS && rph == 0 && !ack && !req)) begin
            if (n > 30000) begin
                tmo = 1'b1;
                break;
            end
            start = 1'b0;
            pd    = 1'b0;
            if (hold_n > 0 && n == hold_n) begin
                hold_ack = 1'b0;
                ack      = 1'b0;
            end
            if (!rs_done && restart_at >= 0 && events.size() >= restart_at) begin
                rs_done    = 1'b1;
                start      = 1'b1;
                sample_idx = 16'(idx + 5);
                label_pos  = ~pos;
                train_en   = ~trn;
            end
            if (!pd_done && pd_at >= 0 && events.size() >= pd_at) begin
                pd_done = 1'b1;
                pd      = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        pd    = 1'b0;
        repeat (3) @(negedge clk);
        early    = (done_cnt != dc0);
        goodness = good;
        pd       = 1'b1;
        @(negedge clk);
        pd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, goodness_out, spike_cnt, err, mem_ren, mem_raddr,
             aerin_addr, req, is_pos, is_train} !== 83'h0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b req=%b addr=%h cnt=%h err=%b need all 0",
                     busy, done, req, aerin_addr, spike_cnt, err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || req !== 1'b0 || mem_ren !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b req=%b ren=%b need 0", busy, req, mem_ren);
        end
    endtask

    task automatic test_all_zero();
        bit tmo, early, got;
        int idx;
        idx = int'($urandom_range(0, 20));
        mem.delete();
        build_expected(idx);
        run_sample(idx, 1'b1, 1'b0, 32'h1234, -1, -1, 0, tmo, early, got);
        total++;
        if (tmo || !got) begin
            bad++;
            $display("FAIL zero_done got tmo=%b done=%b need tmo=0 done=1", tmo, got);
        end
        total++;
        if (events.size() != 8 || ev_diffs() != 0) begin
            bad++;
            $display("FAIL zero_events got n=%0d diffs=%0d need n=8 diffs=0",
                     events.size(), ev_diffs());
        end
        total++;
        if (spike_cnt !== 16'h0 || goodness_out !== 32'h1234) begin
            bad++;
            $display("FAIL zero_cnt_good got cnt=%h good=%h need 0000/00001234",
                     spike_cnt, goodness_out);
        end
    endtask

    task automatic test_pixels();
        bit tmo, early, got;
        int r0;
        logic [11:0] want [5];
        want = '{12'h000, 12'h01F, 12'h020, 12'h30F, 12'h4FF};
        mem.delete();
        set_pixel(2, 0, 0);
        set_pixel(2, 0, 31);
        set_pixel(2, 0, 32);
        set_pixel(2, 0, 783);
        build_expected(2);
        r0 = rd480;
        run_sample(2, 1'b0, 1'b0, 32'hCAFE_0001, -1, -1, 0, tmo, early, got);
        total++;
        if (tmo || !got || ev_diffs() != 0) begin
            bad++;
            $display("FAIL pix_events got tmo=%b done=%b diffs=%0d need 0/1/0",
                     tmo, got, ev_diffs());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= events.size() || events[i] !== want[i]) begin
                bad++;
                $display("FAIL pix_event%0d got %h need %h", i,
                         (i < events.size()) ? events[i] : 12'hXXX, want[i]);
            end
        end
        total++;
        if (spike_cnt !== 16'd4) begin
            bad++;
            $display("FAIL pix_cnt got %0d need 4", spike_cnt);
        end
        total++;
        if (rd480 - r0 != 1) begin
            bad++;
            $display("FAIL pix_addr480 got %0d reads need 1", rd480 - r0);
        end
    endtask

    task automatic test_random_padding();
        bit tmo, early, got;
        int idx;
        logic [31:0] good;
        idx  = int'($urandom_range(3, 20));
        good = $urandom;
        dmin = 0;
        dmax = 4;
        mem.delete();
        for (int t = 0; t < T_STEPS; t++) begin
            for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                set_pixel(idx, t, int'($urandom_range(0, N_PIX - 1)));
            for (int p = N_PIX; p < WPT * WORD_W; p++)
                set_pixel(idx, t, p);
        end
        build_expected(idx);
        run_sample(idx, 1'b1, 1'b1, good, -1, -1, 0, tmo, early, got);
        total++;
        if (tmo || !got || ev_diffs() != 0) begin
            bad++;
            $display("FAIL rand_events got tmo=%b done=%b n=%0d diffs=%0d need n=%0d diffs=0",
                     tmo, got, events.size(), ev_diffs(), exp_ev.size());
        end
        total++;
        if (spike_cnt !== 16'(exp_pixels()) || goodness_out !== good) begin
            bad++;
            $display("FAIL rand_cnt_good got cnt=%0d good=%h need %0d/%h",
                     spike_cnt, goodness_out, exp_pixels(), good);
        end
        total++;
        if (viol != 0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rand_protocol got viol=%0d err=%b need 0/0", viol, err);
        end
    endtask

    task automatic test_ack_high();
        bit tmo, early, got;
        int v0;
        v0   = viol;
        dmin = 10;
        dmax = 10;
        mem.delete();
        set_pixel(7, 0, 0);
        set_pixel(7, 0, 5);
        set_pixel(7, 4, 400);
        build_expected(7);
        hold_ack = 1'b1;
        ack      = 1'b1;
        run_sample(7, 1'b1, 1'b0, 32'h0BAD_F00D, -1, -1, 10, tmo, early, got);
        total++;
        if (viol != v0) begin
            bad++;
            $display("FAIL ackhigh_protocol got %0d violations need 0", viol - v0);
        end
        total++;
        if (tmo || !got || ev_diffs() != 0) begin
            bad++;
            $display("FAIL ackhigh_events got tmo=%b done=%b diffs=%0d need 0/1/0",
                     tmo, got, ev_diffs());
        end
        dmin = 0;
        dmax = 3;
    endtask

    task automatic test_restart_ignored();
        bit tmo, early, got;
        int a0;
        int idx;
        idx = int'($urandom_range(0, 10));
        a0  = attr_viol;
        mem.delete();
        for (int t = 0; t < T_STEPS; t++)
            set_pixel(idx, t, int'($urandom_range(0, N_PIX - 1)));
        set_pixel(idx + 5, 0, 1);
        build_expected(idx);
        run_sample(idx, 1'b0, 1'b1, 32'h55AA_0F0F, 2, -1, 0, tmo, early, got);
        total++;
        if (tmo || !got || ev_diffs() != 0) begin
            bad++;
            $display("FAIL restart_events got tmo=%b done=%b diffs=%0d need 0/1/0",
                     tmo, got, ev_diffs());
        end
        total++;
        if (attr_viol != a0 || is_pos !== 1'b0 || is_train !== 1'b1) begin
            bad++;
            $display("FAIL restart_attrs got viol=%0d pos=%b train=%b need 0/0/1",
                     attr_viol - a0, is_pos, is_train);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_idle got busy=%b need 0", busy);
        end
    endtask

    task automatic test_err_sticky();
        bit tmo, early, got;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got %b need 0", err);
        end
        mem.delete();
        set_pixel(4, 0, 10);
        set_pixel(4, 1, 20);
        set_pixel(4, 6, 700);
        build_expected(4);
        run_sample(4, 1'b1, 1'b1, 32'h0000_BEEF, -1, 3, 0, tmo, early, got);
        total++;
        if (early || !got || tmo) begin
            bad++;
            $display("FAIL err_done got early=%b done=%b tmo=%b need 0/1/0",
                     early, got, tmo);
        end
        total++;
        if (ev_diffs() != 0 || goodness_out !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL err_stream got diffs=%0d good=%h need 0/0000beef",
                     ev_diffs(), goodness_out);
        end
        repeat (5) @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got %b need 1", err);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        dmin = 20;
        dmax = 20;
        mem.delete();
        set_pixel(9, 0, 100);
        set_pixel(9, 0, 200);
        @(negedge clk);
        sample_idx = 16'd9;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!req && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req !== 1'b1) begin
            bad++;
            $display("FAIL abort_req_wait got req=%b need 1", req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (req !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL abort_async got req=%b busy=%b err=%b need 0/0/0",
                     req, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || req !== 1'b0 || done !== 1'b0 || mem_ren !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got busy=%b req=%b done=%b ren=%b need 0",
                     busy, req, done, mem_ren);
        end
        dmin = 0;
        dmax = 3;
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_pixels();
        test_random_padding();
        test_ack_high();
        test_restart_ignored();
        test_err_sticky();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
